// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined operand adder: default geometry, stage count helper
// and the stage valid vector type for the default build.
package adder_pkg;

  // Integer ceiling division, usable in constant expressions.
  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  localparam int unsigned WaDefault    = 51;
  localparam int unsigned WbDefault    = 14;
  localparam int unsigned ChunkDefault = 17;

  // Carry segments in the default build.
  localparam int unsigned NstgDefault = ceil_div(WaDefault, ChunkDefault);

  // One valid bit per register position: operand capture plus one per carry segment.
  typedef logic [NstgDefault:0] stg_valid_t;

endpackage

// File: rtl/adder_chunk_stage.sv
// One carry segment of the pipelined adder: adds a W-bit slice of both operands plus the
// registered carry of the segment below, and registers the sum slice and carry-out.
module adder_chunk_stage import adder_pkg::*; #(
  parameter int unsigned W   = ChunkDefault,
  parameter int unsigned IDX = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] sum_o,
  output logic         c_o
);

  logic [W:0]   sum_d;
  logic [W-1:0] sum_q;
  logic         c_q;
  logic         cin;

  // Segment add; the lowest segment has nothing below it, so its carry-in is forced to zero.
  always_comb begin
    cin   = c_i & (IDX != 0);
    sum_d = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin};
  end

  // Sum slice and carry-out registers, held while the pipe is stalled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q <= '0;
      c_q   <= 1'b0;
    end else if (en_i) begin
      sum_q <= sum_d[W-1:0];
      c_q   <= sum_d[W];
    end
  end

  assign sum_o = sum_q;
  assign c_o   = c_q;

endmodule

// File: rtl/pipelined_operand_adder.sv
// Pipelined WA-bit + WB-bit adder with valid/ready streaming handshake.
// Operands are captured in an input register, then the carry chain is cut into CHUNK-bit
// segments, one register stage each. Upper operand slices are skewed and finished lower sum
// slices deskewed so every slice of one operation leaves together.
// Build option: define PIPE_ADDER_SIGNED_EN to sign-extend B (two's complement, wrapping sum);
// otherwise B is zero-extended and the sum is exact.
module pipelined_operand_adder import adder_pkg::*; #(
  parameter int unsigned WA    = WaDefault,
  parameter int unsigned WB    = WbDefault,
  parameter int unsigned CHUNK = ChunkDefault
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WA-1:0] in_a,
  input  logic [WB-1:0] in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WA:0]   out_sum
);

  localparam int unsigned NSTG = ceil_div(WA, CHUNK);

  if (WB < 1 || WB > WA || CHUNK < 1) begin : g_bad_param
    $fatal(1, "pipelined_operand_adder: need 1 <= WB <= WA and CHUNK >= 1");
  end

  logic          adv;
  logic [WA:0]   b_ext;
  logic [NSTG:0] vld_q;
  logic [NSTG:0] vld_d;
  logic [NSTG:0] cchain;
  logic          top_q [NSTG+1];

  // The whole pipe moves together; it may move whenever the output slot is free or draining.
  assign out_valid = vld_q[NSTG];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

`ifdef PIPE_ADDER_SIGNED_EN
  assign b_ext = {{(WA + 1 - WB){in_b[WB-1]}}, in_b};
`else
  assign b_ext = {{(WA + 1 - WB){1'b0}}, in_b};
`endif

  // Valid chain next state: shift in in_valid on advance, bubbles travel as zeros.
  always_comb begin
    vld_d = vld_q;
    if (adv) begin
      vld_d[0] = in_valid;
      for (int unsigned k = 1; k <= NSTG; k++) begin
        vld_d[k] = vld_q[k-1];
      end
    end
  end

  // Valid chain register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // Bit WA of ext(B) rides alongside to the output; it combines with the final carry there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= NSTG; k++) begin
        top_q[k] <= 1'b0;
      end
    end else if (adv) begin
      top_q[0] <= b_ext[WA];
      for (int k = 1; k <= NSTG; k++) begin
        top_q[k] <= top_q[k-1];
      end
    end
  end

  assign cchain[0]   = 1'b0;
  assign out_sum[WA] = cchain[NSTG] ^ top_q[NSTG];

  for (genvar i = 0; i < NSTG; i++) begin : g_stg
    localparam int unsigned Lo  = i * CHUNK;
    localparam int unsigned W   = (i == NSTG - 1) ? WA - Lo : CHUNK;
    localparam int unsigned Dsk = NSTG - 1 - i;

    logic [W-1:0] a_q [i+1];
    logic [W-1:0] b_q [i+1];
    logic [W-1:0] sum_c;

    // Operand slice delay line: capture, then wait i cycles for the carry from below.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k <= i; k++) begin
          a_q[k] <= '0;
          b_q[k] <= '0;
        end
      end else if (adv) begin
        a_q[0] <= in_a[Lo +: W];
        b_q[0] <= b_ext[Lo +: W];
        for (int k = 1; k <= i; k++) begin
          a_q[k] <= a_q[k-1];
          b_q[k] <= b_q[k-1];
        end
      end
    end

    adder_chunk_stage #(
      .W   (W),
      .IDX (i)
    ) u_stage (
      .clk_i (clk),
      .rst_i (rst),
      .en_i  (adv),
      .a_i   (a_q[i]),
      .b_i   (b_q[i]),
      .c_i   (cchain[i]),
      .sum_o (sum_c),
      .c_o   (cchain[i+1])
    );

    if (Dsk > 0) begin : g_dsk
      logic [W-1:0] dsk_q [Dsk];

      // Finished slice waits for the upper segments of the same operation.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned k = 0; k < Dsk; k++) begin
            dsk_q[k] <= '0;
          end
        end else if (adv) begin
          dsk_q[0] <= sum_c;
          for (int unsigned k = 1; k < Dsk; k++) begin
            dsk_q[k] <= dsk_q[k-1];
          end
        end
      end

      assign out_sum[Lo +: W] = dsk_q[Dsk-1];
    end else begin : g_top
      assign out_sum[Lo +: W] = sum_c;
    end
  end

endmodule
